// File: rtl/nes_cpu_pkg.sv
// Shared definitions for the 6502-subset core: opcodes, addressing modes,
// ALU operations, status flag positions and instruction cycle encoding.
package nes_cpu_pkg;

  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_ADC_ABS = 8'h6D;
  localparam logic [7:0] OP_ADC_ZPG = 8'h65;
  localparam logic [7:0] OP_ADC_ZPX = 8'h75;
  localparam logic [7:0] OP_ADC_ABX = 8'h7D;
  localparam logic [7:0] OP_ADC_ABY = 8'h79;
  localparam logic [7:0] OP_ADC_IZX = 8'h61;
  localparam logic [7:0] OP_ADC_IZY = 8'h71;
  localparam logic [7:0] OP_SBC_IMM = 8'hE9;
  localparam logic [7:0] OP_SBC_ABS = 8'hED;
  localparam logic [7:0] OP_SBC_ZPG = 8'hE5;
  localparam logic [7:0] OP_SBC_ZPX = 8'hF5;
  localparam logic [7:0] OP_SBC_ABX = 8'hFD;
  localparam logic [7:0] OP_SBC_ABY = 8'hF9;
  localparam logic [7:0] OP_SBC_IZX = 8'hE1;
  localparam logic [7:0] OP_SBC_IZY = 8'hF1;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TYA     = 8'h98;

  typedef enum logic [3:0] {
    AM_IMP, AM_IMM, AM_ZPG, AM_ZPX, AM_ABS, AM_ABX, AM_ABY, AM_IZX, AM_IZY
  } amode_e;

  typedef enum logic [2:0] {
    ALU_PASS, ALU_ADC, ALU_SBC, ALU_INC, ALU_DEC
  } alu_op_e;

  // Status register bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  // Cycle-within-instruction encoding (T0 is always the opcode fetch)
  typedef logic [2:0] cyc_t;
  localparam cyc_t T0 = 3'd0;
  localparam cyc_t T1 = 3'd1;
  localparam cyc_t T2 = 3'd2;
  localparam cyc_t T3 = 3'd3;
  localparam cyc_t T4 = 3'd4;
  localparam cyc_t T5 = 3'd5;

  function automatic amode_e decode_mode(input logic [7:0] op);
    case (op)
      OP_ADC_IMM, OP_SBC_IMM: return AM_IMM;
      OP_ADC_ZPG, OP_SBC_ZPG: return AM_ZPG;
      OP_ADC_ZPX, OP_SBC_ZPX: return AM_ZPX;
      OP_ADC_ABS, OP_SBC_ABS: return AM_ABS;
      OP_ADC_ABX, OP_SBC_ABX: return AM_ABX;
      OP_ADC_ABY, OP_SBC_ABY: return AM_ABY;
      OP_ADC_IZX, OP_SBC_IZX: return AM_IZX;
      OP_ADC_IZY, OP_SBC_IZY: return AM_IZY;
      default:                return AM_IMP;
    endcase
  endfunction

  function automatic logic is_adc(input logic [7:0] op);
    case (op)
      OP_ADC_IMM, OP_ADC_ZPG, OP_ADC_ZPX, OP_ADC_ABS,
      OP_ADC_ABX, OP_ADC_ABY, OP_ADC_IZX, OP_ADC_IZY: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_sbc(input logic [7:0] op);
    case (op)
      OP_SBC_IMM, OP_SBC_ZPG, OP_SBC_ZPX, OP_SBC_ABS,
      OP_SBC_ABX, OP_SBC_ABY, OP_SBC_IZX, OP_SBC_IZY: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nes_cpu_alu.sv
// Combinational ALU: binary add/subtract with carry, increment, decrement
// and pass-through, producing the N, V, Z and C flag candidates.
module nes_cpu_alu
  import nes_cpu_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] m_i,
  input  logic       c_i,
  output logic [7:0] r_o,
  output logic       n_o,
  output logic       v_o,
  output logic       z_o,
  output logic       c_o
);

  logic [7:0] m_eff;
  logic [8:0] sum;

  // Result and flags; SBC reuses the adder with the operand inverted
  always_comb begin
    m_eff = m_i;
    sum   = 9'h000;
    r_o   = a_i;
    c_o   = c_i;
    v_o   = 1'b0;
    case (op_i)
      ALU_ADC, ALU_SBC: begin
        if (op_i == ALU_SBC) m_eff = ~m_i;
        sum = {1'b0, a_i} + {1'b0, m_eff} + {8'h00, c_i};
        r_o = sum[7:0];
        c_o = sum[8];
        v_o = (a_i[7] == m_eff[7]) && (sum[7] != a_i[7]);
      end
      ALU_INC: r_o = a_i + 8'd1;
      ALU_DEC: r_o = a_i - 8'd1;
      default: r_o = a_i;
    endcase
    n_o = r_o[7];
    z_o = (r_o == 8'h00);
  end

endmodule

// File: rtl/nes_cpu_core.sv
// 6502-subset core: register file, per-instruction cycle sequencer,
// opcode decode and read-address multiplexer. Read-only data bus.
module nes_cpu_core
  import nes_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  RESET_P  = 8'h20
) (
  input  logic        clk_ph1,
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic [7:0]  Data_bus,
  output logic [15:0] Addr_bus,
  output logic [7:0]  IR_dbg,
  output logic [7:0]  AC_dbg,
  output logic [7:0]  X_dbg,
  output logic [7:0]  Y_dbg,
  output logic [7:0]  P_dbg,
  output logic [15:0] PC_dbg,
  output logic [2:0]  cycle_dbg
);

  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  zp_q, zp_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  cyc_t        cyc_q, cyc_d;

  amode_e      mode;
  logic [7:0]  idx;
  logic [8:0]  idx_lo_sum;
  logic [15:0] full_sum;
  logic [7:0]  zpx_addr;
  logic [7:0]  zpx_next;
  logic [7:0]  zp_next;
  logic        commit;

  alu_op_e     alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_r;
  logic        alu_n, alu_v, alu_z, alu_c;

  // The second clock phase carries no information for this core
  logic unused_ph2;
  assign unused_ph2 = clk_ph2;

  assign mode       = decode_mode(ir_q);
  assign idx        = (mode == AM_ABX) ? x_q : y_q;
  assign idx_lo_sum = {1'b0, lo_q} + {1'b0, idx};
  assign full_sum   = {hi_q, lo_q} + {8'h00, idx};
  assign zpx_addr   = zp_q + x_q;
  assign zpx_next   = zpx_addr + 8'd1;
  assign zp_next    = zp_q + 8'd1;

  // ALU operation and source register chosen from the current opcode
  always_comb begin
    alu_op = ALU_PASS;
    alu_a  = a_q;
    if (is_adc(ir_q)) begin
      alu_op = ALU_ADC;
    end else if (is_sbc(ir_q)) begin
      alu_op = ALU_SBC;
    end else begin
      case (ir_q)
        OP_INX:  begin alu_op = ALU_INC; alu_a = x_q; end
        OP_INY:  begin alu_op = ALU_INC; alu_a = y_q; end
        OP_DEX:  begin alu_op = ALU_DEC; alu_a = x_q; end
        OP_DEY:  begin alu_op = ALU_DEC; alu_a = y_q; end
        OP_TXA:  alu_a = x_q;
        OP_TYA:  alu_a = y_q;
        default: alu_a = a_q;
      endcase
    end
  end

  nes_cpu_alu u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .m_i  (Data_bus),
    .c_i  (p_q[FLAG_C]),
    .r_o  (alu_r),
    .n_o  (alu_n),
    .v_o  (alu_v),
    .z_o  (alu_z),
    .c_o  (alu_c)
  );

  // Cycle sequencer: address mux, operand capture and final-cycle writeback
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    x_d      = x_q;
    y_d      = y_q;
    p_d      = p_q;
    zp_d     = zp_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cyc_d    = cyc_q;
    Addr_bus = pc_q;
    commit   = 1'b0;

    if (cyc_q == T0) begin
      ir_d  = Data_bus;
      pc_d  = pc_q + 16'd1;
      cyc_d = T1;
    end else begin
      case (mode)
        AM_IMM: begin
          pc_d   = pc_q + 16'd1;
          commit = 1'b1;
        end
        AM_ZPG, AM_ZPX: begin
          case (cyc_q)
            T1: begin zp_d = Data_bus; pc_d = pc_q + 16'd1; cyc_d = T2; end
            T2: begin
              Addr_bus = {8'h00, zp_q};
              if (mode == AM_ZPG) commit = 1'b1;
              else                cyc_d  = T3;
            end
            T3: begin Addr_bus = {8'h00, zpx_addr}; commit = 1'b1; end
            default: cyc_d = T0;
          endcase
        end
        AM_ABS, AM_ABX, AM_ABY: begin
          case (cyc_q)
            T1: begin lo_d = Data_bus; pc_d = pc_q + 16'd1; cyc_d = T2; end
            T2: begin hi_d = Data_bus; pc_d = pc_q + 16'd1; cyc_d = T3; end
            T3: begin
              if (mode == AM_ABS) begin
                Addr_bus = {hi_q, lo_q};
                commit   = 1'b1;
              end else begin
                // Uncorrected high byte first; a carry costs one more cycle
                Addr_bus = {hi_q, idx_lo_sum[7:0]};
                if (idx_lo_sum[8]) cyc_d  = T4;
                else               commit = 1'b1;
              end
            end
            T4: begin Addr_bus = full_sum; commit = 1'b1; end
            default: cyc_d = T0;
          endcase
        end
        AM_IZX: begin
          case (cyc_q)
            T1: begin zp_d = Data_bus; pc_d = pc_q + 16'd1; cyc_d = T2; end
            T2: begin Addr_bus = {8'h00, zp_q}; cyc_d = T3; end
            T3: begin Addr_bus = {8'h00, zpx_addr}; lo_d = Data_bus; cyc_d = T4; end
            T4: begin Addr_bus = {8'h00, zpx_next}; hi_d = Data_bus; cyc_d = T5; end
            T5: begin Addr_bus = {hi_q, lo_q}; commit = 1'b1; end
            default: cyc_d = T0;
          endcase
        end
        AM_IZY: begin
          case (cyc_q)
            T1: begin zp_d = Data_bus; pc_d = pc_q + 16'd1; cyc_d = T2; end
            T2: begin Addr_bus = {8'h00, zp_q}; lo_d = Data_bus; cyc_d = T3; end
            T3: begin Addr_bus = {8'h00, zp_next}; hi_d = Data_bus; cyc_d = T4; end
            T4: begin
              Addr_bus = {hi_q, idx_lo_sum[7:0]};
              if (idx_lo_sum[8]) cyc_d  = T5;
              else               commit = 1'b1;
            end
            T5: begin Addr_bus = full_sum; commit = 1'b1; end
            default: cyc_d = T0;
          endcase
        end
        default: begin
          // Implied ops and unknown opcodes: dummy read at PC, no increment
          commit = 1'b1;
        end
      endcase
    end

    if (commit) begin
      cyc_d = T0;
      if (is_adc(ir_q) || is_sbc(ir_q)) begin
        a_d         = alu_r;
        p_d[FLAG_N] = alu_n;
        p_d[FLAG_V] = alu_v;
        p_d[FLAG_Z] = alu_z;
        p_d[FLAG_C] = alu_c;
      end else begin
        case (ir_q)
          OP_SEC: p_d[FLAG_C] = 1'b1;
          OP_CLC: p_d[FLAG_C] = 1'b0;
          OP_INX, OP_DEX, OP_TAX: begin
            x_d = alu_r; p_d[FLAG_N] = alu_n; p_d[FLAG_Z] = alu_z;
          end
          OP_INY, OP_DEY, OP_TAY: begin
            y_d = alu_r; p_d[FLAG_N] = alu_n; p_d[FLAG_Z] = alu_z;
          end
          OP_TXA, OP_TYA: begin
            a_d = alu_r; p_d[FLAG_N] = alu_n; p_d[FLAG_Z] = alu_z;
          end
          default: ;
        endcase
      end
      p_d[FLAG_U] = 1'b1;
    end
  end

  // Architectural and sequencing state; reset abandons any instruction in flight
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= 8'h00;
      a_q   <= 8'h00;
      x_q   <= 8'h00;
      y_q   <= 8'h00;
      p_q   <= RESET_P;
      zp_q  <= 8'h00;
      lo_q  <= 8'h00;
      hi_q  <= 8'h00;
      cyc_q <= T0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      x_q   <= x_d;
      y_q   <= y_d;
      p_q   <= p_d;
      zp_q  <= zp_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cyc_q <= cyc_d;
    end
  end

  assign IR_dbg    = ir_q;
  assign AC_dbg    = a_q;
  assign X_dbg     = x_q;
  assign Y_dbg     = y_q;
  assign P_dbg     = p_q;
  assign PC_dbg    = pc_q;
  assign cycle_dbg = cyc_q;

endmodule

// File: tb/tb_nes_cpu_core.sv
// Program-driven bench for nes_cpu_core: a 64 KiB memory model feeds the bus,
// expectations are queued per instruction and popped as the core steps.
module tb_nes_cpu_core;

  logic        clk_ph1;
  logic        clk_ph2;
  logic        rst;
  logic [7:0]  Data_bus;
  logic [15:0] Addr_bus;
  logic [7:0]  IR_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg;
  logic [15:0] PC_dbg;
  logic [2:0]  cycle_dbg;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_ADDR = 0;
  localparam int S_A    = 1;
  localparam int S_X    = 2;
  localparam int S_Y    = 3;
  localparam int S_P    = 4;
  localparam int S_PC   = 5;
  localparam int S_IR   = 6;
  localparam int S_CYC  = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];

  nes_cpu_core #(.RESET_PC(16'h0000), .RESET_P(8'h20)) dut (
    .clk_ph1   (clk_ph1),
    .clk_ph2   (clk_ph2),
    .rst       (rst),
    .Data_bus  (Data_bus),
    .Addr_bus  (Addr_bus),
    .IR_dbg    (IR_dbg),
    .AC_dbg    (AC_dbg),
    .X_dbg     (X_dbg),
    .Y_dbg     (Y_dbg),
    .P_dbg     (P_dbg),
    .PC_dbg    (PC_dbg),
    .cycle_dbg (cycle_dbg)
  );

  initial clk_ph1 = 1'b0;
  always #5 clk_ph1 = ~clk_ph1;
  assign clk_ph2  = ~clk_ph1;
  assign Data_bus = mem[Addr_bus];

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_ADDR:  return Addr_bus;
      S_A:     return {8'h00, AC_dbg};
      S_X:     return {8'h00, X_dbg};
      S_Y:     return {8'h00, Y_dbg};
      S_P:     return {8'h00, P_dbg};
      S_PC:    return PC_dbg;
      S_IR:    return {8'h00, IR_dbg};
      default: return {13'h0000, cycle_dbg};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Queue the per-cycle address and cycle number, then step and compare.
  task automatic run_instr(input string nm, input int n,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3,
                           input logic [15:0] a4, input logic [15:0] a5);
    logic [15:0] ad [6];
    ad[0] = a0; ad[1] = a1; ad[2] = a2; ad[3] = a3; ad[4] = a4; ad[5] = a5;
    for (int i = 0; i < n; i++) begin
      push_exp($sformatf("%s_addr_t%0d", nm, i), S_ADDR, ad[i]);
      push_exp($sformatf("%s_cyc_t%0d", nm, i), S_CYC, 16'(i));
    end
    for (int i = 0; i < n; i++) begin
      pop_check();
      pop_check();
      @(negedge clk_ph1);
    end
  endtask

  task automatic expect_regs(input string nm, input logic [7:0] a, input logic [7:0] x,
                             input logic [7:0] y, input logic [7:0] p,
                             input logic [15:0] pc, input logic [7:0] ir);
    push_exp({nm, "_A"},  S_A,  {8'h00, a});
    push_exp({nm, "_X"},  S_X,  {8'h00, x});
    push_exp({nm, "_Y"},  S_Y,  {8'h00, y});
    push_exp({nm, "_P"},  S_P,  {8'h00, p});
    push_exp({nm, "_PC"}, S_PC, pc);
    push_exp({nm, "_IR"}, S_IR, {8'h00, ir});
    for (int i = 0; i < 6; i++) pop_check();
  endtask

  task automatic expect_idle(input string nm);
    push_exp({nm, "_addr"}, S_ADDR, 16'h0000);
    push_exp({nm, "_cyc"},  S_CYC,  16'h0000);
    pop_check();
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of program");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    // Program
    mem[16'h0000] = 8'hC8;                                             // INY
    mem[16'h0001] = 8'hC8;                                             // INY
    mem[16'h0002] = 8'h71; mem[16'h0003] = 8'h80;                      // ADC (80),Y
    mem[16'h0004] = 8'h38;                                             // SEC
    mem[16'h0005] = 8'hE9; mem[16'h0006] = 8'h07;                      // SBC #07
    mem[16'h0007] = 8'h18;                                             // CLC
    mem[16'h0008] = 8'h69; mem[16'h0009] = 8'h50;                      // ADC #50
    mem[16'h000A] = 8'h69; mem[16'h000B] = 8'h50;                      // ADC #50
    mem[16'h000C] = 8'h38;                                             // SEC
    mem[16'h000D] = 8'hE9; mem[16'h000E] = 8'h9B;                      // SBC #9B
    mem[16'h000F] = 8'h38;                                             // SEC
    mem[16'h0010] = 8'hE9; mem[16'h0011] = 8'h06;                      // SBC #06
    mem[16'h0012] = 8'hAA;                                             // TAX
    mem[16'h0013] = 8'hE8;                                             // INX
    mem[16'h0014] = 8'hE8;                                             // INX
    mem[16'h0015] = 8'h7D; mem[16'h0016] = 8'hFF; mem[16'h0017] = 8'h02; // ADC 02FF,X
    mem[16'h0018] = 8'h02;                                             // unknown -> NOP
    mem[16'h0019] = 8'h65; mem[16'h001A] = 8'h40;                      // ADC 40
    mem[16'h001B] = 8'h75; mem[16'h001C] = 8'hFF;                      // ADC FF,X
    mem[16'h001D] = 8'h61; mem[16'h001E] = 8'h7F;                      // ADC (7F,X)
    mem[16'h001F] = 8'h71; mem[16'h0020] = 8'h80;                      // ADC (80),Y (aborted)
    // Data
    mem[16'h0080] = 8'hFF; mem[16'h0081] = 8'h01;
    mem[16'h0201] = 8'h07;
    mem[16'h0300] = 8'h02;
    mem[16'h0040] = 8'h10;
    mem[16'h01FF] = 8'h25;

    rst = 1'b0;
    #590;
    expect_idle("rst");
    expect_regs("rst", 8'h00, 8'h00, 8'h00, 8'h20, 16'h0000, 8'h00);
    #10;
    @(negedge clk_ph1);
    rst = 1'b1;

    run_instr("iny1", 2, 16'h0000, 16'h0001, 0, 0, 0, 0);
    expect_regs("iny1", 8'h00, 8'h00, 8'h01, 8'h20, 16'h0001, 8'hC8);
    run_instr("iny2", 2, 16'h0001, 16'h0002, 0, 0, 0, 0);
    expect_regs("iny2", 8'h00, 8'h00, 8'h02, 8'h20, 16'h0002, 8'hC8);

    run_instr("izy", 6, 16'h0002, 16'h0003, 16'h0080, 16'h0081, 16'h0101, 16'h0201);
    expect_regs("izy", 8'h07, 8'h00, 8'h02, 8'h20, 16'h0004, 8'h71);

    run_instr("sec1", 2, 16'h0004, 16'h0005, 0, 0, 0, 0);
    expect_regs("sec1", 8'h07, 8'h00, 8'h02, 8'h21, 16'h0005, 8'h38);
    run_instr("sbc07", 2, 16'h0005, 16'h0006, 0, 0, 0, 0);
    expect_regs("sbc07", 8'h00, 8'h00, 8'h02, 8'h23, 16'h0007, 8'hE9);
    run_instr("clc", 2, 16'h0007, 16'h0008, 0, 0, 0, 0);
    expect_regs("clc", 8'h00, 8'h00, 8'h02, 8'h22, 16'h0008, 8'h18);
    run_instr("adc50a", 2, 16'h0008, 16'h0009, 0, 0, 0, 0);
    expect_regs("adc50a", 8'h50, 8'h00, 8'h02, 8'h20, 16'h000A, 8'h69);
    run_instr("adc50b", 2, 16'h000A, 16'h000B, 0, 0, 0, 0);
    expect_regs("adc50b", 8'hA0, 8'h00, 8'h02, 8'hE0, 16'h000C, 8'h69);

    run_instr("sec2", 2, 16'h000C, 16'h000D, 0, 0, 0, 0);
    run_instr("sbc9b", 2, 16'h000D, 16'h000E, 0, 0, 0, 0);
    expect_regs("sbc9b", 8'h05, 8'h00, 8'h02, 8'h21, 16'h000F, 8'hE9);
    run_instr("sec3", 2, 16'h000F, 16'h0010, 0, 0, 0, 0);
    run_instr("sbc06", 2, 16'h0010, 16'h0011, 0, 0, 0, 0);
    expect_regs("sbc06", 8'hFF, 8'h00, 8'h02, 8'hA0, 16'h0012, 8'hE9);
    run_instr("tax", 2, 16'h0012, 16'h0013, 0, 0, 0, 0);
    expect_regs("tax", 8'hFF, 8'hFF, 8'h02, 8'hA0, 16'h0013, 8'hAA);
    run_instr("inx_wrap", 2, 16'h0013, 16'h0014, 0, 0, 0, 0);
    expect_regs("inx_wrap", 8'hFF, 8'h00, 8'h02, 8'h22, 16'h0014, 8'hE8);
    run_instr("inx", 2, 16'h0014, 16'h0015, 0, 0, 0, 0);
    expect_regs("inx", 8'hFF, 8'h01, 8'h02, 8'h20, 16'h0015, 8'hE8);

    run_instr("abx_cross", 5, 16'h0015, 16'h0016, 16'h0017, 16'h0200, 16'h0300, 0);
    expect_regs("abx_cross", 8'h01, 8'h01, 8'h02, 8'h21, 16'h0018, 8'h7D);
    run_instr("nop", 2, 16'h0018, 16'h0019, 0, 0, 0, 0);
    expect_regs("nop", 8'h01, 8'h01, 8'h02, 8'h21, 16'h0019, 8'h02);
    run_instr("zpg", 3, 16'h0019, 16'h001A, 16'h0040, 0, 0, 0);
    expect_regs("zpg", 8'h12, 8'h01, 8'h02, 8'h20, 16'h001B, 8'h65);
    run_instr("zpx_wrap", 4, 16'h001B, 16'h001C, 16'h00FF, 16'h0000, 0, 0);
    expect_regs("zpx_wrap", 8'hDA, 8'h01, 8'h02, 8'hA0, 16'h001D, 8'h75);
    run_instr("izx", 6, 16'h001D, 16'h001E, 16'h007F, 16'h0080, 16'h0081, 16'h01FF);
    expect_regs("izx", 8'hFF, 8'h01, 8'h02, 8'hA0, 16'h001F, 8'h61);

    // Abort an indirect-indexed ADC in its fourth cycle
    run_instr("izy_abort", 3, 16'h001F, 16'h0020, 16'h0080, 0, 0, 0);
    push_exp("izy_abort_addr_t3", S_ADDR, 16'h0081);
    push_exp("izy_abort_cyc_t3",  S_CYC,  16'h0003);
    pop_check();
    pop_check();
    rst = 1'b0;
    #1;
    expect_idle("midrst");
    expect_regs("midrst", 8'h00, 8'h00, 8'h00, 8'h20, 16'h0000, 8'h00);
    @(negedge clk_ph1);
    @(negedge clk_ph1);
    expect_regs("midrst_hold", 8'h00, 8'h00, 8'h00, 8'h20, 16'h0000, 8'h00);
    rst = 1'b1;
    run_instr("restart", 2, 16'h0000, 16'h0001, 0, 0, 0, 0);
    expect_regs("restart", 8'h00, 8'h00, 8'h01, 8'h20, 16'h0001, 8'hC8);

    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
